alu_arbiter: RTL and testbench

Shares the 8-bit ALU (`main`: one-hot `in_sel`, `num1`/`num2`, one-hot 7-bit `out_sel`) between two requesters. Sequences each operation as load, execute, capture, and returns the result with a one-cycle acknowledge. It also clears the ALU once after every reset. It sits between the requesting control logic and the ALU, and is the only driver of the ALU's control and operand inputs.

---
 rtl/alu_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 8-bit ALU between two requesters. Each operation is
// sequenced as load, execute, capture, and the result returns with a one-cycle ack.
module alu_arbiter #(
  parameter int EXEC_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] result,
  output logic       err,
  output logic       busy,
  output logic [2:0] alu_in_sel,
  output logic [7:0] alu_num1,
  output logic [7:0] alu_num2,
  output logic [6:0] alu_out_sel,
  input  logic [7:0] alu_result
);

  typedef enum logic [2:0] {
    S_CLR  = 3'd0,
    S_IDLE = 3'd1,
    S_LOAD = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [2:0] SEL_PERSIST = 3'b100;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_RESET   = 3'b001;
  localparam logic [2:0] OP_ILLEGAL  = 3'd7;
  localparam logic [3:0] CNT_INIT    = 4'(EXEC_CYCLES - 1);

  // Op code 0 maps to the most significant out_sel bit.
  function automatic logic [6:0] op_decode(input logic [2:0] op);
    case (op)
      3'd0:    op_decode = 7'b1000000;
      3'd1:    op_decode = 7'b0100000;
      3'd2:    op_decode = 7'b0010000;
      3'd3:    op_decode = 7'b0001000;
      3'd4:    op_decode = 7'b0000100;
      3'd5:    op_decode = 7'b0000010;
      3'd6:    op_decode = 7'b0000001;
      default: op_decode = 7'b0000000;
    endcase
  endfunction

  state_t     state_q;
  logic       ack0_q;
  logic       ack1_q;
  logic       err_q;
  logic       busy_q;
  logic       last_q;
  logic       owner_q;
  logic [7:0] result_q;
  logic [7:0] num1_q;
  logic [7:0] num2_q;
  logic [2:0] in_sel_q;
  logic [6:0] out_sel_q;
  logic [3:0] cnt_q;

  logic       grant1_d;
  logic [2:0] win_op_d;
  logic [7:0] win_a_d;
  logic [7:0] win_b_d;

  // Round-robin winner selection and mux of the winner's op and operands.
  always_comb begin
    grant1_d = 1'b0;
    if (req0 && req1) begin
      grant1_d = ~last_q;
    end else begin
      grant1_d = req1;
    end
    if (grant1_d) begin
      win_op_d = op1;
      win_a_d  = a1;
      win_b_d  = b1;
    end else begin
      win_op_d = op0;
      win_a_d  = a0;
      win_b_d  = b0;
    end
  end

  // Sequencer: state, round-robin bookkeeping and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_CLR;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b1;
      result_q  <= 8'd0;
      in_sel_q  <= SEL_RESET;
      out_sel_q <= 7'd0;
      num1_q    <= 8'd0;
      num2_q    <= 8'd0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      cnt_q     <= 4'd0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_CLR: begin
          state_q   <= S_IDLE;
          in_sel_q  <= SEL_PERSIST;
          out_sel_q <= 7'd0;
          busy_q    <= 1'b0;
        end
        S_IDLE: begin
          if (req0 || req1) begin
            owner_q <= grant1_d;
            busy_q  <= 1'b1;
            if (win_op_d == OP_ILLEGAL) begin
              // Illegal op bypasses the ALU entirely; operands stay as they were.
              state_q  <= S_DONE;
              result_q <= 8'd0;
              err_q    <= 1'b1;
              last_q   <= grant1_d;
              ack0_q   <= ~grant1_d;
              ack1_q   <= grant1_d;
            end else begin
              state_q   <= S_LOAD;
              in_sel_q  <= SEL_LOAD;
              num1_q    <= win_a_d;
              num2_q    <= win_b_d;
              out_sel_q <= op_decode(win_op_d);
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_LOAD: begin
          state_q  <= S_EXEC;
          in_sel_q <= SEL_PERSIST;
          cnt_q    <= CNT_INIT;
        end
        S_EXEC: begin
          if (cnt_q == 4'd0) begin
            state_q   <= S_DONE;
            result_q  <= alu_result;
            out_sel_q <= 7'd0;
            last_q    <= owner_q;
            ack0_q    <= ~owner_q;
            ack1_q    <= owner_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= S_CLR;
          in_sel_q  <= SEL_RESET;
          out_sel_q <= 7'd0;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign result      = result_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign alu_in_sel  = in_sel_q;
  assign alu_num1    = num1_q;
  assign alu_num2    = num2_q;
  assign alu_out_sel = out_sel_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized requesters, with a
// cycle-level reference model of the arbitration and operation timeline.
module tb_alu_arbiter;

  localparam int EC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [2:0] op0 = 3'd0, op1 = 3'd0;
  logic [7:0] a0 = 8'd0, b0 = 8'd0, a1 = 8'd0, b1 = 8'd0;
  logic       ack0, ack1, err, busy;
  logic [7:0] result, alu_num1, alu_num2, alu_result;
  logic [2:0] alu_in_sel;
  logic [6:0] alu_out_sel;

  logic       req0_2 = 1'b0, req1_2 = 1'b0;
  logic [2:0] op0_2 = 3'd0, op1_2 = 3'd0;
  logic [7:0] a0_2 = 8'd0, b0_2 = 8'd0, a1_2 = 8'd0, b1_2 = 8'd0;
  logic       ack0_2, ack1_2, err_2, busy_2;
  logic [7:0] result_2, num1_2, num2_2, alu_result_2;
  logic [2:0] in_sel_2;
  logic [6:0] out_sel_2;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_fn(input int op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      0:       alu_fn = a + b;
      1:       alu_fn = a - b;
      2:       alu_fn = a & b;
      3:       alu_fn = a | b;
      4:       alu_fn = a ^ b;
      5:       alu_fn = ~a;
      6:       alu_fn = b - a;
      default: alu_fn = 8'd0;
    endcase
  endfunction

  function automatic int sel_index(input logic [6:0] sel);
    int idx = 7;
    for (int i = 0; i < 7; i++) begin
      if (sel[6-i]) idx = i;
    end
    return idx;
  endfunction

  assign alu_result   = alu_fn(sel_index(alu_out_sel), alu_num1, alu_num2);
  assign alu_result_2 = alu_fn(sel_index(out_sel_2), num1_2, num2_2);

  alu_arbiter #(.EXEC_CYCLES(EC)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .ack0(ack0), .ack1(ack1),
    .result(result), .err(err), .busy(busy), .alu_in_sel(alu_in_sel),
    .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_out_sel(alu_out_sel),
    .alu_result(alu_result)
  );

  alu_arbiter #(.EXEC_CYCLES(1)) dut_ec1 (
    .clk(clk), .rst(rst), .req0(req0_2), .req1(req1_2), .op0(op0_2), .op1(op1_2),
    .a0(a0_2), .b0(b0_2), .a1(a1_2), .b1(b1_2), .ack0(ack0_2), .ack1(ack1_2),
    .result(result_2), .err(err_2), .busy(busy_2), .alu_in_sel(in_sel_2),
    .alu_num1(num1_2), .alu_num2(num2_2), .alu_out_sel(out_sel_2),
    .alu_result(alu_result_2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: expected outputs of the current cycle.
  logic       e_ack0, e_ack1, e_err, e_busy;
  logic [2:0] e_in_sel;
  logic [6:0] e_out_sel;
  logic [7:0] e_num1, e_num2, e_result;
  int         m_phase;
  bit         m_clr, m_last, m_who;
  int         m_op;
  logic [7:0] m_a, m_b;

  task automatic model_reset();
    m_phase = -1; m_clr = 1'b1; m_last = 1'b1; m_who = 1'b0;
    e_ack0 = 1'b0; e_ack1 = 1'b0; e_err = 1'b0; e_busy = 1'b1;
    e_in_sel = 3'b001; e_out_sel = 7'd0; e_num1 = 8'd0; e_num2 = 8'd0; e_result = 8'd0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        e_ack0 = 1'b0; e_ack1 = 1'b0; e_err = 1'b0;
        if (m_clr) begin
          m_clr = 1'b0; e_in_sel = 3'b100; e_busy = 1'b0;
        end else if (m_phase < 0) begin
          if (req0 || req1) begin
            m_who = (req0 && req1) ? !m_last : req1;
            m_op  = m_who ? int'(op1) : int'(op0);
            m_a   = m_who ? a1 : a0;
            m_b   = m_who ? b1 : b0;
            e_busy = 1'b1;
            if (m_op == 7) begin
              m_phase = EC + 1;
              e_result = 8'd0; e_err = 1'b1; m_last = m_who;
              e_ack0 = !m_who; e_ack1 = m_who;
            end else begin
              m_phase = 0;
              e_in_sel = 3'b010; e_num1 = m_a; e_num2 = m_b;
              e_out_sel = 7'd1 << (6 - m_op);
            end
          end
        end else begin
          m_phase++;
          if (m_phase <= EC) begin
            e_in_sel = 3'b100;
          end else if (m_phase == EC + 1) begin
            e_result = alu_fn(m_op, m_a, m_b);
            e_out_sel = 7'd0; m_last = m_who;
            e_ack0 = !m_who; e_ack1 = m_who;
          end else begin
            m_phase = -1; e_busy = 1'b0;
          end
        end
      end
    end
  end

  wire [37:0] dut_vec = {ack0, ack1, err, busy, alu_in_sel, alu_out_sel, alu_num1, alu_num2, result};
  wire [37:0] exp_vec = {e_ack0, e_ack1, e_err, e_busy, e_in_sel, e_out_sel, e_num1, e_num2, e_result};
  localparam logic [37:0] RST_VEC = {1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 7'd0, 8'd0, 8'd0, 8'd0};

  initial begin
    forever begin
      @(negedge clk);
      chk("cycle", 64'(dut_vec), 64'(exp_vec));
    end
  end

  int  nack, rel, ack_c, g;
  int  ack_who[8];
  int  ack_cyc[8];
  bit  s0, s1, lo0, lo1;

  initial begin
    // Reset: values while held, one CLR cycle after release.
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_vec", 64'(dut_vec), 64'(RST_VEC));
    rst = 1'b0;
    #1 chk("clr_in_sel", 64'(alu_in_sel), 64'(3'b001));
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_in_sel", 64'(alu_in_sel), 64'(3'b100));

    // Contention: both held, each re-raised one cycle after its ack.
    req0 = 1'b1; op0 = 3'd1; a0 = 8'h90; b0 = 8'h21;
    req1 = 1'b1; op1 = 3'd6; a1 = 8'h13; b1 = 8'hC4;
    nack = 0; lo0 = 1'b0; lo1 = 1'b0;
    for (int c = 0; c < 40 && nack < 4; c++) begin
      @(negedge clk);
      s0 = ack0; s1 = ack1;
      if (s0 || s1) begin
        ack_who[nack] = int'(s1); ack_cyc[nack] = cyc; nack++;
      end
      @(posedge clk); #1;
      if (lo0) begin req0 = 1'b1; lo0 = 1'b0; end
      if (lo1) begin req1 = 1'b1; lo1 = 1'b0; end
      if (s0) begin req0 = 1'b0; lo0 = 1'b1; end
      if (s1) begin req1 = 1'b0; lo1 = 1'b1; end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("cont_nack", 64'(nack), 64'd4);
    for (int k = 0; k < nack; k++) begin
      chk("cont_who", 64'(ack_who[k]), 64'(k % 2));
      if (k > 0) chk("cont_gap", 64'(ack_cyc[k] - ack_cyc[k-1]), 64'(EC + 3));
    end
    repeat (3) @(negedge clk);

    // Single request, op 0 (add).
    req0 = 1'b1; op0 = 3'd0; a0 = 8'h57; b0 = 8'h1A;
    @(negedge clk);
    chk("load_in_sel", 64'(alu_in_sel), 64'(3'b010));
    chk("load_num1", 64'(alu_num1), 64'(8'h57));
    chk("load_num2", 64'(alu_num2), 64'(8'h1A));
    chk("load_out_sel", 64'(alu_out_sel), 64'(7'b1000000));
    @(negedge clk);
    chk("exec1_in_sel", 64'(alu_in_sel), 64'(3'b100));
    @(negedge clk);
    chk("exec2_in_sel", 64'(alu_in_sel), 64'(3'b100));
    @(negedge clk);
    chk("single_ack0", 64'(ack0), 64'd1);
    chk("single_result", 64'(result), 64'(8'h71));
    chk("single_err", 64'(err), 64'd0);
    @(posedge clk); #1 req0 = 1'b0;
    repeat (2) @(negedge clk);

    // Illegal op on requester 1.
    req1 = 1'b1; op1 = 3'd7; a1 = 8'hAA; b1 = 8'h55;
    @(negedge clk);
    chk("ill_ack1", 64'(ack1), 64'd1);
    chk("ill_err", 64'(err), 64'd1);
    chk("ill_result", 64'(result), 64'd0);
    chk("ill_in_sel", 64'(alu_in_sel), 64'(3'b100));
    @(posedge clk); #1 req1 = 1'b0;
    @(negedge clk);
    chk("ill_err_clear", 64'(err), 64'd0);
    repeat (2) @(negedge clk);

    // Reset during EXEC, request still held afterwards.
    req0 = 1'b1; op0 = 3'd2; a0 = 8'h3C; b0 = 8'h0F;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async", 64'(dut_vec), 64'(RST_VEC));
    @(negedge clk);
    rst = 1'b0; rel = cyc; nack = 0; ack_c = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ack0) begin
        ack_c = cyc; nack++;
        @(posedge clk); #1 req0 = 1'b0;
      end
    end
    chk("rif_nack", 64'(nack), 64'd1);
    chk("rif_lat", 64'(ack_c - rel), 64'd5);

    // EXEC_CYCLES=1 instance with operand change mid-flight.
    req0_2 = 1'b1; op0_2 = 3'd0; a0_2 = 8'h02; b0_2 = 8'h04;
    @(negedge clk);
    g = cyc;
    chk("ec1_load_in_sel", 64'(in_sel_2), 64'(3'b010));
    chk("ec1_load_num1", 64'(num1_2), 64'(8'h02));
    chk("ec1_load_num2", 64'(num2_2), 64'(8'h04));
    chk("ec1_load_out_sel", 64'(out_sel_2), 64'(7'b1000000));
    chk("ec1_busy", 64'(busy_2), 64'd1);
    @(posedge clk); #1 a0_2 = 8'hFF;
    @(negedge clk);
    chk("ec1_exec_num1", 64'(num1_2), 64'(8'h02));
    chk("ec1_exec_in_sel", 64'(in_sel_2), 64'(3'b100));
    nack = 0; ack_c = 0;
    for (int c = 0; c < 6 && nack == 0; c++) begin
      if (ack0_2) begin ack_c = cyc; nack++; end
      else @(negedge clk);
    end
    chk("ec1_nack", 64'(nack), 64'd1);
    chk("ec1_lat", 64'(ack_c - g), 64'd2);
    chk("ec1_result", 64'(result_2), 64'(8'h06));
    chk("ec1_err", 64'(err_2), 64'd0);
    chk("ec1_ack1", 64'(ack1_2), 64'd0);
    @(posedge clk); #1 req0_2 = 1'b0;

    // Randomized requesters obeying the hold-until-ack contract.
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      s0 = ack0; s1 = ack1;
      if (k == 350) #2 rst = 1'b1;
      if (k == 351) rst = 1'b0;
      @(posedge clk); #1;
      if (s0) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1; op0 = 3'($urandom_range(0, 7));
        a0 = 8'($urandom); b0 = 8'($urandom);
      end
      if (s1) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; op1 = 3'($urandom_range(0, 7));
        a1 = 8'($urandom); b1 = 8'($urandom);
      end
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
